// File: rtl/ext_loader_pkg.sv
// Shared opcodes, FSM encoding and word geometry for the external-memory loader.
package ext_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
  localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
  localparam logic [1:0] OP_DUMP_DMEM = 2'd2;
  localparam logic [1:0] OP_RUN       = 2'd3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StDumpReq  = 3'd2,
    StDumpWait = 3'd3,
    StDumpOut  = 3'd4,
    StRun      = 3'd5
  } state_e;

endpackage

// File: rtl/ext_addr_counter.sv
// Loadable word-address up-counter paired with a remaining-count down-counter.
module ext_addr_counter
  import ext_loader_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      base_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [31:0]      addr_o,
  output logic [31:0]      addr_nxt_o,
  output logic             last_o
);

  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = base_i;
      remain_d = count_i;
    end else if (step_i) begin
      addr_d   = addr_q + 32'(WORD_BYTES);
      remain_d = remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  // Next address is exposed so registered strobes can carry the address they refer to.
  assign addr_o     = addr_q;
  assign addr_nxt_o = addr_d;
  assign last_o     = (remain_q == CNT_W'(1));

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side controller driving the CPU's IMEM/DMEM external ports: load, dump and timed run.
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_BYTES = 2048,
  parameter int unsigned DMEM_BYTES = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              cpu_enable,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;
  logic   dmem_sel_q, dmem_sel_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   wr_ready_q, wr_ready_d;
  logic   rd_valid_q, rd_valid_d;
  logic   rd_last_q, rd_last_d;
  logic   wen_ext_q, wen_ext_d;
  logic   wen_ext_2_q, wen_ext_2_d;
  logic   ren_ext_2_q, ren_ext_2_d;
  logic   cpu_enable_q, cpu_enable_d;
  logic   done_q, done_d;
  logic   error_q, error_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] wdata_ext_q, wdata_ext_d;
  logic [DATA_W-1:0] wdata_ext_2_q, wdata_ext_2_d;
  logic [31:0]       addr_ext_q, addr_ext_d;
  logic [31:0]       addr_ext_2_q, addr_ext_2_d;

  logic        accept, cmd_bad, cmd_zero, wr_fire, rd_fire, in_run;
  logic        cnt_load, cnt_step, cnt_last;
  logic [31:0] cnt_addr, cnt_addr_nxt;
  logic [32:0] span_end, span_lim;

  // IMEM is write-only from this block; its read data is deliberately ignored.
  logic unused_rdata_ext;
  assign unused_rdata_ext = ^rdata_ext;

  // 33-bit span so base + 4*count can never wrap past the limit.
  always_comb begin
    span_end = {1'b0, cmd_base} + 33'(cmd_count) * 33'(WORD_BYTES);
    span_lim = (cmd_op == OP_LOAD_IMEM) ? 33'(IMEM_BYTES) : 33'(DMEM_BYTES);
    cmd_bad  = (cmd_base[1:0] != 2'b00) || ((cmd_op != OP_RUN) && (span_end > span_lim));
  end

  assign accept   = (state_q == StIdle) && cmd_valid && cmd_ready_q;
  assign cmd_zero = (cmd_count == '0);
  assign wr_fire  = (state_q == StLoad) && wr_valid && wr_ready_q;
  assign rd_fire  = (state_q == StDumpOut) && rd_valid_q && rd_ready;
  assign in_run   = (state_q == StRun);
  assign cnt_load = accept && !cmd_bad;
  assign cnt_step = wr_fire || rd_fire || in_run;

  ext_addr_counter #(
    .CNT_W (CNT_W)
  ) u_addr_counter (
    .clk        (clk),
    .arst       (arst),
    .load_i     (cnt_load),
    .step_i     (cnt_step),
    .base_i     (cmd_base),
    .count_i    (cmd_count),
    .addr_o     (cnt_addr),
    .addr_nxt_o (cnt_addr_nxt),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= StIdle;
      dmem_sel_q    <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_last_q     <= 1'b0;
      addr_ext_q    <= '0;
      wen_ext_q     <= 1'b0;
      wdata_ext_q   <= '0;
      addr_ext_2_q  <= '0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      wdata_ext_2_q <= '0;
      cpu_enable_q  <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dmem_sel_q    <= dmem_sel_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_ready_q    <= wr_ready_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      rd_last_q     <= rd_last_d;
      addr_ext_q    <= addr_ext_d;
      wen_ext_q     <= wen_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      ren_ext_2_q   <= ren_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      cpu_enable_q  <= cpu_enable_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dmem_sel_d = dmem_sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dmem_sel_d = (cmd_op != OP_LOAD_IMEM);
          if (!cmd_bad && !cmd_zero) begin
            case (cmd_op)
              OP_LOAD_IMEM, OP_LOAD_DMEM: state_d = StLoad;
              OP_DUMP_DMEM:               state_d = StDumpReq;
              default:                    state_d = StRun;
            endcase
          end
        end
      end
      StLoad:     if (wr_fire && cnt_last) state_d = StIdle;
      StDumpReq:  state_d = StDumpWait;
      StDumpWait: state_d = StDumpOut;
      StDumpOut:  if (rd_fire) state_d = cnt_last ? StIdle : StDumpReq;
      StRun:      if (cnt_last) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so that every port comes straight from a flop.
  always_comb begin
    cmd_ready_d   = (state_d == StIdle);
    wr_ready_d    = (state_d == StLoad);
    cpu_enable_d  = (state_d == StRun);
    wen_ext_d     = wr_fire && !dmem_sel_q;
    wen_ext_2_d   = wr_fire && dmem_sel_q;
    ren_ext_2_d   = (state_d == StDumpReq);
    addr_ext_d    = addr_ext_q;
    wdata_ext_d   = wdata_ext_q;
    addr_ext_2_d  = addr_ext_2_q;
    wdata_ext_2_d = wdata_ext_2_q;
    if (wen_ext_d) begin
      addr_ext_d  = cnt_addr;
      wdata_ext_d = wr_data;
    end
    if (wen_ext_2_d) begin
      addr_ext_2_d  = cnt_addr;
      wdata_ext_2_d = wr_data;
    end
    if (ren_ext_2_d) begin
      addr_ext_2_d = cnt_addr_nxt;
    end
    rd_valid_d = (state_d == StDumpOut);
    rd_data_d  = (state_q == StDumpWait) ? rdata_ext_2 : rd_data_q;
    rd_last_d  = rd_valid_d && cnt_last;
    done_d     = (accept && !cmd_bad && cmd_zero) || (wr_fire && cnt_last) ||
                 (rd_fire && cnt_last) || (in_run && cnt_last);
    error_d    = accept && cmd_bad;
  end

  assign cmd_ready   = cmd_ready_q;
  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = ren_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign cpu_enable  = cpu_enable_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader with SRAM models and a word-level reference.
module tb_ext_mem_loader;

  typedef logic [31:0] word_q_t[$];
  typedef bit bit_q_t[$];

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_base;
  logic [15:0] cmd_count;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [31:0] addr_ext, wdata_ext, rdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ext_mem_loader #(
    .DATA_W     (32),
    .IMEM_BYTES (2048),
    .DMEM_BYTES (4096),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_base    (cmd_base),
    .cmd_count   (cmd_count),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .cpu_enable  (cpu_enable),
    .done        (done),
    .error       (error)
  );

  // SRAMs with one-cycle read latency, plus reference images kept by the bench.
  logic [31:0] imem [512];
  logic [31:0] dmem [1024];
  logic [31:0] ref_imem [512];
  logic [31:0] ref_dmem [1024];

  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= imem[addr_ext[10:2]];
    if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
  end

  // Observation log filled at every falling edge.
  int unsigned   cyc = 0;
  logic [64:0]   wq[$];
  int            wcyc[$];
  logic [31:0]   rq[$];
  int done_cnt, err_cnt, en_cnt, inv_viol, done_cyc, first_en, last_en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!arst) begin
      if (wen_ext) begin wq.push_back({1'b0, addr_ext, wdata_ext}); wcyc.push_back(int'(cyc)); end
      if (wen_ext_2) begin wq.push_back({1'b1, addr_ext_2, wdata_ext_2}); wcyc.push_back(int'(cyc)); end
      if (ren_ext_2) rq.push_back(addr_ext_2);
      if (done) begin done_cnt++; done_cyc = int'(cyc); end
      if (error) err_cnt++;
      if (cpu_enable) begin
        if (en_cnt == 0) first_en = int'(cyc);
        en_cnt++;
        last_en = int'(cyc);
      end
      if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) inv_viol++;
    end
  end

  task automatic clear_mon();
    wq.delete(); wcyc.delete(); rq.delete();
    done_cnt = 0; err_cnt = 0; en_cnt = 0; inv_viol = 0;
    done_cyc = -1; first_en = -1; last_en = -1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] base, input logic [15:0] cnt);
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_count = cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random gaps.
  task automatic feed_words(input word_q_t w, input int mode);
    int i, g;
    bit tog;
    i = 0; g = 0; tog = 1'b0;
    while (i < w.size() && g < 1000) begin
      @(negedge clk);
      g++;
      tog = !tog;
      if (wr_ready && (mode == 0 || (mode == 1 && tog) || (mode == 2 && $urandom_range(1, 0) == 1))) begin
        wr_valid = 1'b1; wr_data = w[i]; i++;
      end else begin
        wr_valid = 1'b0;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n_tests++;
    if (i != w.size()) begin
      n_fail++;
      $display("FAIL feed_words got=%0d want=%0d", i, w.size());
    end
  endtask

  task automatic drain_dump(input int n, input int stall, output word_q_t got, output bit_q_t lasts,
                            output bit held);
    got = {}; lasts = {}; held = 1'b1;
    for (int k = 0; k < n; k++) begin
      int g;
      logic [31:0] d0;
      g = 0;
      @(negedge clk);
      while (!rd_valid && g < 20) begin @(negedge clk); g++; end
      if (!rd_valid) break;
      if (k == 0 && stall > 0) begin
        d0 = rd_data;
        repeat (stall) begin
          @(negedge clk);
          if (!rd_valid || rd_data !== d0) held = 1'b0;
        end
      end
      got.push_back(rd_data);
      lasts.push_back(rd_last);
      rd_ready = 1'b1;
      @(posedge clk);
      #1 rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [0:0] chk;
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, wr_ready, rd_valid, rd_data, rd_last, addr_ext, wen_ext, ren_ext, wdata_ext,
         addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=nonzero want=all zero");
    end
    arst = 1'b0;
    @(negedge clk);
    chk = cmd_ready;
    n_tests++;
    if (chk !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", chk); end
  endtask

  task automatic test_load_imem();
    word_q_t w;
    logic [64:0] exp_e, got_e;
    w = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    clear_mon();
    issue_cmd(2'd0, 32'h0, 16'd3);
    feed_words(w, 0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (wq.size() != 3) begin n_fail++; $display("FAIL load_imem_count got=%0d want=3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      exp_e = {1'b0, 32'(4 * i), w[i]};
      got_e = (i < wq.size()) ? wq[i] : 'x;
      n_tests++;
      if (got_e !== exp_e) begin
        n_fail++;
        $display("FAIL load_imem_wr%0d got=%h want=%h", i, got_e, exp_e);
      end
      if (i < 3) ref_imem[i] = w[i];
    end
    n_tests++;
    if (wcyc.size() != 3 || wcyc[2] - wcyc[0] != 2) begin
      n_fail++;
      $display("FAIL load_imem_rate got=%0d want=3 consecutive", wcyc.size());
    end
    n_tests++;
    if (done_cnt != 1 || wcyc.size() != 3 || done_cyc != wcyc[2]) begin
      n_fail++;
      $display("FAIL load_imem_done got=cnt%0d cyc%0d want=cnt1 on last wen", done_cnt, done_cyc);
    end
    n_tests++;
    if (imem[1] !== 32'h2002_0007) begin
      n_fail++;
      $display("FAIL load_imem_readback got=%h want=20020007", imem[1]);
    end
  endtask

  task automatic test_dump();
    word_q_t got;
    bit_q_t  lasts;
    bit      held;
    dmem[4] = 32'hDEAD_BEEF; ref_dmem[4] = 32'hDEAD_BEEF;
    dmem[5] = 32'h1234_5678; ref_dmem[5] = 32'h1234_5678;
    clear_mon();
    issue_cmd(2'd2, 32'h10, 16'd2);
    drain_dump(2, 4, got, lasts, held);
    repeat (2) @(negedge clk);
    n_tests++;
    if (!held) begin n_fail++; $display("FAIL dump_hold got=unstable want=stable"); end
    n_tests++;
    if (got.size() != 2) begin n_fail++; $display("FAIL dump_count got=%0d want=2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= got.size() || got[i] !== ref_dmem[4 + i] || lasts[i] != (i == 1)) begin
        n_fail++;
        $display("FAIL dump_word%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 32'hx,
                 ref_dmem[4 + i]);
      end
    end
    n_tests++;
    if (done_cnt != 1 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL dump_done got=done%0d wr%0d want=done1 wr0", done_cnt, wq.size());
    end
    n_tests++;
    if (rq.size() != 2 || rq[0] !== 32'h10 || rq[1] !== 32'h14) begin
      n_fail++;
      $display("FAIL dump_read_addrs got=%0d reads want=2 at 10,14", rq.size());
    end
  endtask

  task automatic test_run(input int n);
    int g;
    clear_mon();
    issue_cmd(2'd3, 32'h0, 16'(n));
    g = 0;
    while (done_cnt == 0 && g < n + 20) begin @(negedge clk); g++; end
    @(negedge clk);
    n_tests++;
    if (en_cnt != n || last_en - first_en + 1 != n) begin
      n_fail++;
      $display("FAIL run_enable got=%0d want=%0d", en_cnt, n);
    end
    n_tests++;
    if (done_cnt != 1 || done_cyc != last_en + 1) begin
      n_fail++;
      $display("FAIL run_done got=cyc%0d want=cyc%0d", done_cyc, last_en + 1);
    end
    n_tests++;
    if (inv_viol != 0 || wq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL run_strobes got=%0d want=0", inv_viol + wq.size() + rq.size());
    end
  endtask

  task automatic test_reject();
    logic [1:0]  ops[5]   = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] bases[5] = '{32'hFFC, 32'h2, 32'h100, 32'h0, 32'h800};
    logic [15:0] cnts[5]  = '{16'd2, 16'd1, 16'd0, 16'hFFFF, 16'd0};
    int          errs[5]  = '{1, 1, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      issue_cmd(ops[i], bases[i], cnts[i]);
      repeat (3) @(negedge clk);
      n_tests++;
      if (err_cnt != errs[i] || done_cnt != 1 - errs[i] || wq.size() != 0 || rq.size() != 0 ||
          en_cnt != 0) begin
        n_fail++;
        $display("FAIL reject%0d got=err%0d done%0d wr%0d want=err%0d done%0d wr0", i, err_cnt,
                 done_cnt, wq.size(), errs[i], 1 - errs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    word_q_t w;
    logic [64:0] exp_e, got_e;
    w = '{32'hA5A5_0001, 32'hA5A5_0002};
    clear_mon();
    issue_cmd(2'd0, 32'h40, 16'd5);
    feed_words(w, 0);
    @(negedge clk);
    arst = 1'b1;
    #1;
    n_tests++;
    if ({cmd_ready, wr_ready, rd_valid, rd_data, rd_last, addr_ext, wen_ext, ren_ext, wdata_ext,
         addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, done, error} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=nonzero want=all zero");
    end
    n_tests++;
    if (wq.size() != 2 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_partial got=wr%0d done%0d want=wr2 done0", wq.size(), done_cnt);
    end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b want=1", cmd_ready); end
    w = '{32'($urandom), 32'($urandom)};
    clear_mon();
    issue_cmd(2'd1, 32'h200, 16'd2);
    feed_words(w, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_e = {1'b1, 32'(32'h200 + 4 * i), w[i]};
      got_e = (i < wq.size()) ? wq[i] : 'x;
      ref_dmem[128 + i] = w[i];
      n_tests++;
      if (got_e !== exp_e) begin
        n_fail++;
        $display("FAIL midreset_reload%0d got=%h want=%h", i, got_e, exp_e);
      end
    end
    n_tests++;
    if (done_cnt != 1 || wq.size() != 2) begin
      n_fail++;
      $display("FAIL midreset_reload_done got=done%0d wr%0d want=done1 wr2", done_cnt, wq.size());
    end
  endtask

  // Throttled load that ends exactly at the top of DMEM.
  task automatic test_throttled_load();
    word_q_t w;
    logic [64:0] exp_e, got_e;
    w = {};
    for (int i = 0; i < 6; i++) w.push_back(32'($urandom));
    clear_mon();
    issue_cmd(2'd1, 32'hFE8, 16'd6);
    feed_words(w, 1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (wq.size() != 6 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL throttle_count got=%0d err%0d want=6 err0", wq.size(), err_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      exp_e = {1'b1, 32'(32'hFE8 + 4 * i), w[i]};
      got_e = (i < wq.size()) ? wq[i] : 'x;
      ref_dmem[1018 + i] = w[i];
      n_tests++;
      if (got_e !== exp_e || dmem[1018 + i] !== w[i]) begin
        n_fail++;
        $display("FAIL throttle_wr%0d got=%h want=%h", i, got_e, exp_e);
      end
    end
    n_tests++;
    if (done_cnt != 1 || wcyc.size() != 6 || done_cyc != wcyc[5]) begin
      n_fail++;
      $display("FAIL throttle_done got=cnt%0d cyc%0d want=cnt1 on last wen", done_cnt, done_cyc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [1:0]  op;
      logic [31:0] base;
      logic [15:0] cnt;
      logic [64:0] exp_e, got_e;
      int          lim, g;
      bit          legal, held;
      word_q_t     w, got;
      bit_q_t      lasts;
      op   = 2'($urandom_range(3, 0));
      cnt  = 16'($urandom_range(6, 0));
      lim  = (op == 2'd0) ? 2048 : 4096;
      base = 32'($urandom_range(lim / 4, 0) * 4);
      if ($urandom_range(7, 0) == 0) base = base + 32'($urandom_range(3, 1));
      legal = (base[1:0] == 2'b00) && (op == 2'd3 || int'(base) + 4 * int'(cnt) <= lim);
      clear_mon();
      issue_cmd(op, base, cnt);
      if (!legal || cnt == 0) begin
        repeat (3) @(negedge clk);
        n_tests++;
        if (err_cnt != int'(!legal) || done_cnt != int'(legal) || wq.size() != 0) begin
          n_fail++;
          $display("FAIL rand%0d_status got=err%0d done%0d want=err%0d done%0d", it, err_cnt,
                   done_cnt, int'(!legal), int'(legal));
        end
      end else if (op < 2'd2) begin
        w = {};
        for (int i = 0; i < int'(cnt); i++) w.push_back(32'($urandom));
        feed_words(w, 2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wq.size() != int'(cnt) || done_cnt != 1) begin
          n_fail++;
          $display("FAIL rand%0d_load got=wr%0d done%0d want=wr%0d done1", it, wq.size(),
                   done_cnt, cnt);
        end
        for (int i = 0; i < int'(cnt); i++) begin
          exp_e = {op[0], 32'(base + 32'(4 * i)), w[i]};
          got_e = (i < wq.size()) ? wq[i] : 'x;
          if (op == 2'd0) ref_imem[int'(base >> 2) + i] = w[i];
          else ref_dmem[int'(base >> 2) + i] = w[i];
          n_tests++;
          if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL rand%0d_wr%0d got=%h want=%h", it, i, got_e, exp_e);
          end
        end
      end else if (op == 2'd2) begin
        drain_dump(int'(cnt), 0, got, lasts, held);
        repeat (2) @(negedge clk);
        n_tests++;
        if (got.size() != int'(cnt) || done_cnt != 1) begin
          n_fail++;
          $display("FAIL rand%0d_dump got=%0d want=%0d", it, got.size(), cnt);
        end
        for (int i = 0; i < got.size(); i++) begin
          n_tests++;
          if (got[i] !== ref_dmem[int'(base >> 2) + i] || lasts[i] != (i == int'(cnt) - 1)) begin
            n_fail++;
            $display("FAIL rand%0d_rd%0d got=%h want=%h", it, i, got[i],
                     ref_dmem[int'(base >> 2) + i]);
          end
        end
      end else begin
        g = 0;
        while (done_cnt == 0 && g < 40) begin @(negedge clk); g++; end
        @(negedge clk);
        n_tests++;
        if (en_cnt != int'(cnt) || done_cyc != last_en + 1 || inv_viol != 0) begin
          n_fail++;
          $display("FAIL rand%0d_run got=%0d want=%0d", it, en_cnt, cnt);
        end
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_count = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin imem[i] = 32'(i * 7); ref_imem[i] = 32'(i * 7); end
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 32'(i) ^ 32'h5A00_0000;
      ref_dmem[i] = 32'(i) ^ 32'h5A00_0000;
    end
    clear_mon();
    test_reset();
    test_load_imem();
    test_dump();
    test_run(10);
    test_run(int'($urandom_range(30, 1)));
    test_reject();
    test_reset_mid_load();
    test_throttled_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
